// File: rtl/jtag_rxtx_fifo_if.sv
`default_nettype none
// ============================================================================
// Module      : jtag_rxtx_fifo_if
// Description : User-side handshake bundle of the virtual-JTAG RX/TX bridge.
//               slave  : the bridge (drives RX head, TX backpressure, status)
//               master : the user logic (consumes RX, offers TX words)
// Signals     : rx_data/rx_valid/rx_ready   RX FIFO head, FWFT
//               tx_data/tx_valid/tx_ready   TX FIFO write port
//               rx_count/tx_count           FIFO occupancy
//               rx_overflow/tx_underflow    sticky error flags
// Revision    : 1.0 - initial release
// ============================================================================
interface jtag_rxtx_fifo_if #(
    parameter int DATA_W   = 32,
    parameter int RX_DEPTH = 16,
    parameter int TX_DEPTH = 16
) ();
    logic [DATA_W-1:0]           rx_data;
    logic                        rx_valid;
    logic                        rx_ready;
    logic [DATA_W-1:0]           tx_data;
    logic                        tx_valid;
    logic                        tx_ready;
    logic [$clog2(RX_DEPTH):0]   rx_count;
    logic [$clog2(TX_DEPTH):0]   tx_count;
    logic                        rx_overflow;
    logic                        tx_underflow;

    modport slave (
        output rx_data, rx_valid, tx_ready, rx_count, tx_count,
               rx_overflow, tx_underflow,
        input  rx_ready, tx_data, tx_valid
    );

    modport master (
        input  rx_data, rx_valid, tx_ready, rx_count, tx_count,
               rx_overflow, tx_underflow,
        output rx_ready, tx_data, tx_valid
    );
endinterface
`default_nettype wire

// File: rtl/jtag_rxtx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : jtag_rxtx_fifo
// Description : Virtual-JTAG data bridge in the tck domain. Host PUSH words
//               land in an RX FIFO, user words leave through a TX FIFO for
//               host POP. Optional STATUS command (macro JTAG_RXTX_STATUS_EN)
//               reports occupancy/error flags and clears the sticky flags.
// Ports       : tck, reset                 clock, synchronous active-high reset
//               tdi, ir_in, vs_cdr/sdr/udr virtual-JTAG inputs
//               tdo                        virtual-JTAG output (combinational)
//               user                       user-side interface (slave modport)
// Revision    : 1.0 - initial release
// ============================================================================
module jtag_rxtx_fifo #(
    parameter int DATA_W   = 32,
    parameter int RX_DEPTH = 16,
    parameter int TX_DEPTH = 16,
    parameter int IR_W     = 3
) (
    input  wire logic            tck,
    input  wire logic            reset,
    input  wire logic            tdi,
    input  wire logic [IR_W-1:0] ir_in,
    input  wire logic            vs_cdr,
    input  wire logic            vs_sdr,
    input  wire logic            vs_udr,
    output logic                 tdo,
    jtag_rxtx_fifo_if.slave      user
);
    localparam int RX_AW = $clog2(RX_DEPTH);
    localparam int TX_AW = $clog2(TX_DEPTH);
    localparam int RX_CW = RX_AW + 1;
    localparam int TX_CW = TX_AW + 1;

    localparam logic [IR_W-1:0] IR_PUSH   = IR_W'(1);
    localparam logic [IR_W-1:0] IR_POP    = IR_W'(2);
`ifdef JTAG_RXTX_STATUS_EN
    localparam logic [IR_W-1:0] IR_STATUS = IR_W'(3);
`endif

    // ---------------- RX FIFO (host -> user) ----------------
    logic [DATA_W-1:0] rx_mem [RX_DEPTH];
    logic [RX_AW-1:0]  rx_wptr_q, rx_rptr_q;
    logic [RX_CW-1:0]  rx_count_q, rx_count_d;
    logic              w_rx_full, w_rx_empty, w_push_cmd, w_rx_wr, w_rx_rd;

    // ---------------- TX FIFO (user -> host) ----------------
    logic [DATA_W-1:0] tx_mem [TX_DEPTH];
    logic [TX_AW-1:0]  tx_wptr_q, tx_rptr_q;
    logic [TX_CW-1:0]  tx_count_q, tx_count_d;
    logic              w_tx_full, w_tx_empty, w_pop_cmd, w_tx_wr, w_tx_rd;

    logic [DATA_W-1:0] push_sr_q, pop_sr_q;
    logic              rx_overflow_q, tx_underflow_q;
    logic              w_flag_clr;

    assign w_rx_full  = (rx_count_q == RX_CW'(RX_DEPTH));
    assign w_rx_empty = (rx_count_q == '0);
    assign w_tx_full  = (tx_count_q == TX_CW'(TX_DEPTH));
    assign w_tx_empty = (tx_count_q == '0);

    // A full RX drops the host word even if the user reads in the same
    // cycle: fullness is judged on the state before the edge.
    assign w_push_cmd = vs_udr && (ir_in == IR_PUSH);
    assign w_rx_wr    = w_push_cmd && !w_rx_full;
    assign w_rx_rd    = !w_rx_empty && user.rx_ready;

    assign w_pop_cmd  = vs_cdr && (ir_in == IR_POP);
    assign w_tx_rd    = w_pop_cmd && !w_tx_empty;
    assign w_tx_wr    = user.tx_valid && !w_tx_full;

    always_comb begin
        rx_count_d = rx_count_q;
        case ({w_rx_wr, w_rx_rd})
            2'b10:   rx_count_d = rx_count_q + RX_CW'(1);
            2'b01:   rx_count_d = rx_count_q - RX_CW'(1);
            default: rx_count_d = rx_count_q;
        endcase
    end

    always_comb begin
        tx_count_d = tx_count_q;
        case ({w_tx_wr, w_tx_rd})
            2'b10:   tx_count_d = tx_count_q + TX_CW'(1);
            2'b01:   tx_count_d = tx_count_q - TX_CW'(1);
            default: tx_count_d = tx_count_q;
        endcase
    end

    // FIFO storage is intentionally not reset.
    always_ff @(posedge tck) begin
        if (w_rx_wr) rx_mem[rx_wptr_q] <= push_sr_q;
        if (w_tx_wr) tx_mem[tx_wptr_q] <= user.tx_data;
    end

    always_ff @(posedge tck) begin
        if (reset) begin
            rx_wptr_q  <= '0;
            rx_rptr_q  <= '0;
            rx_count_q <= '0;
            tx_wptr_q  <= '0;
            tx_rptr_q  <= '0;
            tx_count_q <= '0;
        end else begin
            if (w_rx_wr) rx_wptr_q <= rx_wptr_q + RX_AW'(1);
            if (w_rx_rd) rx_rptr_q <= rx_rptr_q + RX_AW'(1);
            if (w_tx_wr) tx_wptr_q <= tx_wptr_q + TX_AW'(1);
            if (w_tx_rd) tx_rptr_q <= tx_rptr_q + TX_AW'(1);
            rx_count_q <= rx_count_d;
            tx_count_q <= tx_count_d;
        end
    end

    // PUSH and POP shift registers, LSB first.
    always_ff @(posedge tck) begin
        if (reset) begin
            push_sr_q <= '0;
            pop_sr_q  <= '0;
        end else begin
            if (vs_sdr && (ir_in == IR_PUSH))
                push_sr_q <= {tdi, push_sr_q[DATA_W-1:1]};
            if (w_pop_cmd)
                pop_sr_q <= w_tx_empty ? '0 : tx_mem[tx_rptr_q];
            else if (vs_sdr && (ir_in == IR_POP))
                pop_sr_q <= {tdi, pop_sr_q[DATA_W-1:1]};
        end
    end

`ifdef JTAG_RXTX_STATUS_EN
    logic [DATA_W-1:0] status_sr_q;
    logic [DATA_W-1:0] w_status_word;

    assign w_flag_clr = vs_cdr && (ir_in == IR_STATUS);

    always_comb begin
        w_status_word        = '0;
        w_status_word[0]     = w_rx_full;
        w_status_word[1]     = w_rx_empty;
        w_status_word[2]     = w_tx_full;
        w_status_word[3]     = w_tx_empty;
        w_status_word[4]     = rx_overflow_q;
        w_status_word[5]     = tx_underflow_q;
        w_status_word[15:8]  = 8'(rx_count_q);
        w_status_word[23:16] = 8'(tx_count_q);
    end

    always_ff @(posedge tck) begin
        if (reset)
            status_sr_q <= '0;
        else if (w_flag_clr)
            status_sr_q <= w_status_word;
        else if (vs_sdr && (ir_in == IR_STATUS))
            status_sr_q <= {tdi, status_sr_q[DATA_W-1:1]};
    end
`else
    assign w_flag_clr = 1'b0;
`endif

    // Sticky flags: a coinciding set beats the clear-on-read.
    always_ff @(posedge tck) begin
        if (reset) begin
            rx_overflow_q  <= 1'b0;
            tx_underflow_q <= 1'b0;
        end else begin
            rx_overflow_q  <= (rx_overflow_q  && !w_flag_clr) || (w_push_cmd && w_rx_full);
            tx_underflow_q <= (tx_underflow_q && !w_flag_clr) || (w_pop_cmd && w_tx_empty);
        end
    end

    always_comb begin
        tdo = tdi;
        case (ir_in)
            IR_PUSH:   tdo = push_sr_q[0];
            IR_POP:    tdo = pop_sr_q[0];
`ifdef JTAG_RXTX_STATUS_EN
            IR_STATUS: tdo = status_sr_q[0];
`endif
            default:   tdo = tdi;
        endcase
    end

    assign user.rx_data      = rx_mem[rx_rptr_q];
    assign user.rx_valid     = !w_rx_empty;
    assign user.tx_ready     = !w_tx_full;
    assign user.rx_count     = rx_count_q;
    assign user.tx_count     = tx_count_q;
    assign user.rx_overflow  = rx_overflow_q;
    assign user.tx_underflow = tx_underflow_q;
endmodule
`default_nettype wire
